// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, RV32I opcodes and the issue payload layout.
// Imported by the decoder and the issue-stage skid buffer.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam int unsigned ISSUE_PAYLOAD_W = 32 + 32 + 4 + 5 + 1 + 1;

    typedef struct packed {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        wb_en;
        logic        illegal;
    } issue_payload_t;

    // funct3 -> ALU op for the base (f7 == 0) encodings shared by OP and OP-IMM
    function automatic logic [3:0] f3_base_ctrl(input logic [2:0] f3);
        logic [3:0] c;
        case (f3)
            3'b000:  c = ALU_ADD;
            3'b001:  c = ALU_SLL;
            3'b010:  c = ALU_SLT;
            3'b011:  c = ALU_SLTU;
            3'b100:  c = ALU_XOR;
            3'b101:  c = ALU_SRL;
            3'b110:  c = ALU_OR;
            default: c = ALU_AND;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_ctrl_decode32.sv
// Combinational RV32I ALU decoder: instruction, pc and register operands -> issue payload.
// Illegal instructions produce a zeroed operand/ctrl payload with illegal set.
module alu_ctrl_decode32
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output issue_payload_t  payload
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd_f;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    logic [31:0] shamt;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign rd_f   = instr[11:7];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_u  = {instr[31:12], 12'b0};
    assign shamt  = {27'b0, instr[24:20]};

    logic        legal;
    logic [3:0]  ctrl;
    logic [31:0] op_a;
    logic [31:0] op_b;

    always_comb begin
        legal = 1'b0;
        ctrl  = ALU_ADD;
        op_a  = '0;
        op_b  = '0;
        case (opcode)
            OPC_OP: begin
                op_a = rs1_data;
                op_b = rs2_data;
                if (f7 == F7_BASE) begin
                    legal = 1'b1;
                    ctrl  = f3_base_ctrl(f3);
                end else if (f7 == F7_ALT && f3 == 3'b000) begin
                    legal = 1'b1;
                    ctrl  = ALU_SUB;
                end else if (f7 == F7_ALT && f3 == 3'b101) begin
                    legal = 1'b1;
                    ctrl  = ALU_SRA;
                end
            end
            OPC_OPIMM: begin
                op_a = rs1_data;
                op_b = imm_i;
                ctrl = f3_base_ctrl(f3);
                if (f3 == 3'b001) begin
                    op_b  = shamt;
                    legal = (f7 == F7_BASE);
                end else if (f3 == 3'b101) begin
                    op_b  = shamt;
                    legal = (f7 == F7_BASE) || (f7 == F7_ALT);
                    ctrl  = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                end else begin
                    legal = 1'b1;
                end
            end
            OPC_LUI: begin
                legal = 1'b1;
                op_b  = imm_u;
            end
            OPC_AUIPC: begin
                legal = 1'b1;
                op_a  = pc;
                op_b  = imm_u;
            end
            default: legal = 1'b0;
        endcase

        payload.rs1     = legal ? op_a : '0;
        payload.rs2     = legal ? op_b : '0;
        payload.ctrl    = legal ? ctrl : ALU_ADD;
        payload.rd      = rd_f;
        payload.wb_en   = legal && (rd_f != 5'd0);
        payload.illegal = !legal;
    end

endmodule

// File: rtl/alu_issue_decode32.sv
// ALU issue stage: decodes RV32I ALU instructions and issues them to EX through a
// 2-entry skid buffer, giving a registered in_ready at full throughput.
module alu_issue_decode32
    import alu_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter bit          DROP_ILLEG = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_rs1,
    output logic [XLEN-1:0] alu_rs2,
    output logic [3:0]      alu_ctrl,
    output logic [4:0]      rd,
    output logic            wb_en,
    output logic            illegal
);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_TWO
    } buf_state_t;

    buf_state_t     state_q, state_d;
    issue_payload_t dec;
    issue_payload_t out_q;
    issue_payload_t skid_q;
    logic           in_ready_q;

    alu_ctrl_decode32 #(
        .XLEN(XLEN)
    ) u_decode (
        .instr   (instr),
        .pc      (pc),
        .rs1_data(rs1_data),
        .rs2_data(rs2_data),
        .payload (dec)
    );

    logic accept;
    logic drain;
    logic load_out;
    logic load_skid;
    logic skid_to_out;

    // A dropped illegal instruction still completes the input handshake but loads nothing
    assign accept = in_valid && in_ready_q && !(DROP_ILLEG && dec.illegal);
    assign drain  = (state_q != ST_EMPTY) && out_ready;

    always_comb begin
        state_d     = state_q;
        load_out    = 1'b0;
        load_skid   = 1'b0;
        skid_to_out = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d  = ST_ONE;
                    load_out = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && drain) begin
                    load_out = 1'b1;
                end else if (accept) begin
                    state_d   = ST_TWO;
                    load_skid = 1'b1;
                end else if (drain) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (drain) begin
                    state_d     = ST_ONE;
                    skid_to_out = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
            state_d     = ST_EMPTY;
            load_out    = 1'b0;
            load_skid   = 1'b0;
            skid_to_out = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
            out_q      <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_TWO);
            if (load_out) begin
                out_q <= dec;
            end else if (skid_to_out) begin
                out_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= dec;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign alu_rs1   = out_q.rs1;
    assign alu_rs2   = out_q.rs2;
    assign alu_ctrl  = out_q.ctrl;
    assign rd        = out_q.rd;
    assign wb_en     = out_q.wb_en;
    assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_alu_issue_decode32.sv
// Scoreboard bench for alu_issue_decode32: directed vectors push expected payloads,
// a negedge monitor pops and compares on every output transfer.
module tb_alu_issue_decode32;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_valid2 = 1'b0;
    logic        out_ready = 1'b1;
    logic        out_ready2 = 1'b1;
    logic [31:0] instr = '0;
    logic [31:0] pc = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;

    logic        in_ready, out_valid, wb_en, illegal;
    logic [31:0] alu_rs1, alu_rs2;
    logic [3:0]  alu_ctrl;
    logic [4:0]  rd;

    logic        in_ready2, out_valid2, wb_en2, illegal2;
    logic [31:0] alu_rs1_2, alu_rs2_2;
    logic [3:0]  alu_ctrl2;
    logic [4:0]  rd2;

    int n_vec = 0;
    int n_err = 0;
    issue_payload_t exp_q[$];

    always #5 clk = ~clk;

    alu_issue_decode32 #(.XLEN(32), .DROP_ILLEG(1'b0)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .out_valid(out_valid), .out_ready(out_ready), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2),
        .alu_ctrl(alu_ctrl), .rd(rd), .wb_en(wb_en), .illegal(illegal)
    );

    alu_issue_decode32 #(.XLEN(32), .DROP_ILLEG(1'b1)) dut_drop (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid2), .in_ready(in_ready2),
        .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .out_valid(out_valid2), .out_ready(out_ready2), .alu_rs1(alu_rs1_2), .alu_rs2(alu_rs2_2),
        .alu_ctrl(alu_ctrl2), .rd(rd2), .wb_en(wb_en2), .illegal(illegal2)
    );

    function automatic issue_payload_t mk(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] c, input logic [4:0] r,
                                          input logic w, input logic il);
        issue_payload_t p;
        p.rs1 = a; p.rs2 = b; p.ctrl = c; p.rd = r; p.wb_en = w; p.illegal = il;
        return p;
    endfunction

    function automatic issue_payload_t cur_out();
        return mk(alu_rs1, alu_rs2, alu_ctrl, rd, wb_en, illegal);
    endfunction

    task automatic chk(input string name, input logic [74:0] act, input logic [74:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every output transfer must match the oldest outstanding expectation
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_issue: got %h expected no transfer", cur_out());
                end else begin
                    issue_payload_t e;
                    e = exp_q.pop_front();
                    if (cur_out() !== e) begin
                        n_err++;
                        $display("FAIL payload: got %h expected %h", cur_out(), e);
                    end
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after the transfer
    task automatic issue(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a,
                         input logic [31:0] b, input issue_payload_t e);
        int n;
        instr = i; pc = p; rs1_data = a; rs2_data = b; in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 100);
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 within 100 cycles");
        end else begin
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_outstanding", 75'(exp_q.size()), 75'd0);
    endtask

    initial begin
        issue_payload_t first;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_out_valid", 75'(out_valid), 75'd0);
        chk("rst_in_ready", 75'(in_ready), 75'd1);
        chk("rst_payload", cur_out(), 75'd0);

        // Basic decode with EX always ready
        out_ready = 1'b1;
        issue(32'h002081B3, 32'h0, 32'd5, 32'd7, mk(32'd5, 32'd7, ALU_ADD, 5'd3, 1'b1, 1'b0));
        chk("latency_out_valid", 75'(out_valid), 75'd1);
        issue(32'h40435293, 32'h0, 32'h8000_0000, 32'd1, mk(32'h8000_0000, 32'd4, ALU_SRA, 5'd5, 1'b1, 1'b0));
        issue(32'h123450B7, 32'h0, 32'd9, 32'd9, mk(32'd0, 32'h1234_5000, ALU_ADD, 5'd1, 1'b1, 1'b0));
        issue(32'h00001097, 32'h100, 32'd9, 32'd9, mk(32'h100, 32'h1000, ALU_ADD, 5'd1, 1'b1, 1'b0));
        issue(32'h40208233, 32'h0, 32'd10, 32'd3, mk(32'd10, 32'd3, ALU_SUB, 5'd4, 1'b1, 1'b0));
        issue(32'hFFF00093, 32'h0, 32'd0, 32'd6, mk(32'd0, 32'hFFFF_FFFF, ALU_ADD, 5'd1, 1'b1, 1'b0));
        issue(32'h0020B3B3, 32'h0, 32'd1, 32'd2, mk(32'd1, 32'd2, ALU_SLTU, 5'd7, 1'b1, 1'b0));
        issue(32'h0F00C113, 32'h0, 32'h55, 32'd0, mk(32'h55, 32'hF0, ALU_XOR, 5'd2, 1'b1, 1'b0));
        // Illegal encodings and the rd==0 writeback suppression
        issue(32'h0000057F, 32'h0, 32'd1, 32'd2, mk(32'd0, 32'd0, ALU_ADD, 5'd10, 1'b0, 1'b1));
        issue(32'h022081B3, 32'h0, 32'd1, 32'd2, mk(32'd0, 32'd0, ALU_ADD, 5'd3, 1'b0, 1'b1));
        issue(32'h40109093, 32'h0, 32'd1, 32'd2, mk(32'd0, 32'd0, ALU_ADD, 5'd1, 1'b0, 1'b1));
        issue(32'h00000013, 32'h0, 32'd9, 32'd2, mk(32'd9, 32'd0, ALU_ADD, 5'd0, 1'b0, 1'b0));
        wait_drain();

        // Back-to-back stream with EX stalled for three cycles
        out_ready = 1'b0;
        first = mk(32'h1000, 32'd0, ALU_ADD, 5'd1, 1'b1, 1'b0);
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    issue((32'(i) << 20) | (32'd1 << 15) | (32'(i + 1) << 7) | 32'h13, 32'h0,
                          32'h1000 + 32'(i), 32'd0,
                          mk(32'h1000 + 32'(i), 32'(i), ALU_ADD, 5'(i + 1), 1'b1, 1'b0));
                end
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                chk("stall_in_ready", 75'(in_ready), 75'd0);
                chk("stall_hold_1", cur_out(), first);
                @(posedge clk); #1;
                chk("stall_hold_2", cur_out(), first);
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // Flush while full, with a new instruction offered the same cycle
        out_ready = 1'b0;
        issue(32'h002081B3, 32'h0, 32'd1, 32'd1, mk(32'd1, 32'd1, ALU_ADD, 5'd3, 1'b1, 1'b0));
        issue(32'h002081B3, 32'h0, 32'd2, 32'd2, mk(32'd2, 32'd2, ALU_ADD, 5'd3, 1'b1, 1'b0));
        chk("two_in_ready", 75'(in_ready), 75'd0);
        instr = 32'h123450B7; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        chk("flush_out_valid", 75'(out_valid), 75'd0);
        chk("flush_in_ready", 75'(in_ready), 75'd1);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("flush_no_issue", 75'(out_valid), 75'd0);

        // DROP_ILLEG=1 instance: illegal is consumed silently, legal still issues
        instr = 32'h0000007F; in_valid2 = 1'b1;
        @(negedge clk);
        chk("drop_in_ready", 75'(in_ready2), 75'd1);
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        chk("drop_out_valid_0", 75'(out_valid2), 75'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("drop_out_valid_1", 75'(out_valid2), 75'd0);
        instr = 32'h002081B3; rs1_data = 32'd5; rs2_data = 32'd7; in_valid2 = 1'b1;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        chk("drop_legal_valid", 75'(out_valid2), 75'd1);
        chk("drop_legal_payload",
            mk(alu_rs1_2, alu_rs2_2, alu_ctrl2, rd2, wb_en2, illegal2),
            mk(32'd5, 32'd7, ALU_ADD, 5'd3, 1'b1, 1'b0));

        // Reset with entries buffered discards them
        out_ready = 1'b0;
        issue(32'h002081B3, 32'h0, 32'd3, 32'd3, mk(32'd3, 32'd3, ALU_ADD, 5'd3, 1'b1, 1'b0));
        rst = 1'b1; flush = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        chk("midrst_out_valid", 75'(out_valid), 75'd0);
        chk("midrst_payload", cur_out(), 75'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
